// File: rtl/bus_pkg.sv
// bus_pkg: shared state encoding and limits for the serial bus arbiter.
package bus_pkg;
  localparam int STATE_W = 3;
  localparam int MAX_MASTERS = 8;
  typedef enum logic [STATE_W-1:0] {IDLE, GRANT, ADDR, WAIT_SLV, BUSY} state_e;
endpackage

// File: rtl/rr_picker.sv
// rr_picker: combinational winner select, round-robin from last+1 or fixed lowest-index.
module rr_picker #(
  parameter int N = 4,
  parameter int IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  input  logic          rr,
  output logic [N-1:0]  win,
  output logic [IW-1:0] idx,
  output logic          any
);
  always_comb begin
    int c;
    c = 0;
    win = '0;
    idx = '0;
    any = 1'b0;
    for (int i = 0; i < N; i++) begin
      c = rr ? (int'(last) + 1 + i) % N : i;
      if (!any && req[c]) begin
        any = 1'b1;
        win[c] = 1'b1;
        idx = IW'(c);
      end
    end
  end
endmodule

// File: rtl/bus_arbiter_n.sv
// bus_arbiter_n: serial-request bus arbiter with address capture, split parking and slave timeout.
module bus_arbiter_n
  import bus_pkg::*;
#(
  parameter int NUM_MASTERS = 4,
  parameter int ADDR_W = 2,
  parameter int RR_MODE = 1,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic [NUM_MASTERS-1:0] m_tx,
  output logic [NUM_MASTERS-1:0] m_rx,
  output logic [NUM_MASTERS-1:0] grant,
  output logic [ADDR_W-1:0]      addr,
  output logic                   addr_rdy,
  input  logic                   slv_ready,
  input  logic                   slv_split,
  input  logic                   split_release,
  input  logic                   slv_responded,
  output logic                   timeout_err
);
  localparam int IW = $clog2(NUM_MASTERS);
  localparam int CW = 10;
  localparam int BW = 2;
  state_e state_q, state_d;
  logic [IW-1:0] win_q, win_d, last_q, last_d, park_idx_q, park_idx_d;
  logic [NUM_MASTERS-1:0] grant_q, grant_d, m_rx_q, m_rx_d;
  logic [ADDR_W-1:0] addr_q, addr_d, sh_q, sh_d, park_addr_q, park_addr_d;
  logic [BW-1:0] bit_q, bit_d;
  logic [CW-1:0] wait_q, wait_d;
  logic addr_rdy_q, addr_rdy_d, terr_q, terr_d, nack_q, nack_d;
  logic park_v_q, park_v_d, rel_q, rel_d, replay_q, replay_d;
  logic [NUM_MASTERS-1:0] req, park_oh, pwin;
  logic [IW-1:0] pidx;
  logic pany;
  assign park_oh = NUM_MASTERS'(1) << park_idx_q;
  assign req = ~m_tx & ~(park_v_q ? park_oh : '0);
  rr_picker #(.N(NUM_MASTERS), .IW(IW)) u_pick (
    .req(req), .last(last_q), .rr(RR_MODE != 0), .win(pwin), .idx(pidx), .any(pany)
  );
  always_comb begin
    state_d = state_q;
    win_d = win_q;
    last_d = last_q;
    park_idx_d = park_idx_q;
    grant_d = grant_q;
    m_rx_d = '1;
    addr_d = addr_q;
    sh_d = sh_q;
    park_addr_d = park_addr_q;
    bit_d = bit_q;
    wait_d = wait_q;
    addr_rdy_d = 1'b0;
    terr_d = 1'b0;
    nack_d = 1'b0;
    park_v_d = park_v_q;
    rel_d = rel_q | (split_release & park_v_q);
    replay_d = replay_q;
    // second NACK cycle of an aborted master; arbitration waits for it
    if (nack_q) m_rx_d[win_q] = 1'b0;
    case (state_q)
      IDLE: begin
        if (!nack_q && rel_d) begin
          win_d = park_idx_q;
          last_d = park_idx_q;
          grant_d = park_oh;
          m_rx_d = ~park_oh;
          replay_d = 1'b1;
          park_v_d = 1'b0;
          rel_d = 1'b0;
          state_d = GRANT;
        end else if (!nack_q && pany) begin
          win_d = pidx;
          last_d = pidx;
          grant_d = pwin;
          m_rx_d = ~pwin;
          replay_d = 1'b0;
          state_d = GRANT;
        end
      end
      GRANT: begin
        bit_d = '0;
        wait_d = '0;
        addr_d = replay_q ? park_addr_q : addr_q;
        addr_rdy_d = replay_q;
        state_d = replay_q ? WAIT_SLV : ADDR;
      end
      ADDR: begin
        sh_d = ADDR_W'({sh_q, m_tx[win_q]});
        bit_d = bit_q + 1'b1;
        if (bit_q == BW'(ADDR_W - 1)) begin
          addr_d = sh_d;
          addr_rdy_d = 1'b1;
          state_d = WAIT_SLV;
        end
      end
      WAIT_SLV: begin
        wait_d = wait_q + 1'b1;
        if (slv_ready) begin
          state_d = BUSY;
        end else if (slv_split && !park_v_q) begin
          park_v_d = 1'b1;
          park_idx_d = win_q;
          park_addr_d = addr_q;
          grant_d = '0;
          state_d = IDLE;
        end else if (slv_split || wait_q == CW'(TIMEOUT - 1)) begin
          terr_d = 1'b1;
          m_rx_d[win_q] = 1'b0;
          nack_d = 1'b1;
          grant_d = '0;
          state_d = IDLE;
        end
      end
      BUSY: begin
        if (slv_responded) begin
          grant_d = '0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      win_q <= '0;
      last_q <= IW'(NUM_MASTERS - 1);
      park_idx_q <= '0;
      grant_q <= '0;
      m_rx_q <= '1;
      addr_q <= '0;
      sh_q <= '0;
      park_addr_q <= '0;
      bit_q <= '0;
      wait_q <= '0;
      addr_rdy_q <= 1'b0;
      terr_q <= 1'b0;
      nack_q <= 1'b0;
      park_v_q <= 1'b0;
      rel_q <= 1'b0;
      replay_q <= 1'b0;
    end else begin
      state_q <= state_d;
      win_q <= win_d;
      last_q <= last_d;
      park_idx_q <= park_idx_d;
      grant_q <= grant_d;
      m_rx_q <= m_rx_d;
      addr_q <= addr_d;
      sh_q <= sh_d;
      park_addr_q <= park_addr_d;
      bit_q <= bit_d;
      wait_q <= wait_d;
      addr_rdy_q <= addr_rdy_d;
      terr_q <= terr_d;
      nack_q <= nack_d;
      park_v_q <= park_v_d;
      rel_q <= rel_d;
      replay_q <= replay_d;
    end
  end
  assign grant = grant_q;
  assign m_rx = m_rx_q;
  assign addr = addr_q;
  assign addr_rdy = addr_rdy_q;
  assign timeout_err = terr_q;
endmodule

// File: tb/tb_bus_arbiter_n.sv
// tb_bus_arbiter_n: directed vector table plus hand sequences for split, timeout, reset and priority modes.
module tb_bus_arbiter_n;
  logic clk = 1'b0, rstn = 1'b0;
  logic [3:0] m_tx = 4'hF, m_tx0 = 4'hF;
  logic slv_ready = 1'b0, slv_split = 1'b0, split_release = 1'b0, slv_responded = 1'b0;
  logic [3:0] m_rx, grant, m_rx0, grant0;
  logic [1:0] addr, addr0;
  logic addr_rdy, terr, addr_rdy0, terr0;
  int ncmp = 0, nbad = 0;
  typedef struct {
    logic [3:0] tx;
    logic sr, rs;
    logic [3:0] eg, erx;
    logic [1:0] ea;
    logic ear;
  } vec_t;
  vec_t tbl[19];
  always #5 clk = ~clk;
  bus_arbiter_n #(.NUM_MASTERS(4), .ADDR_W(2), .RR_MODE(1), .TIMEOUT(8)) dut (
    .clk(clk), .rstn(rstn), .m_tx(m_tx), .m_rx(m_rx), .grant(grant), .addr(addr),
    .addr_rdy(addr_rdy), .slv_ready(slv_ready), .slv_split(slv_split),
    .split_release(split_release), .slv_responded(slv_responded), .timeout_err(terr)
  );
  bus_arbiter_n #(.NUM_MASTERS(4), .ADDR_W(2), .RR_MODE(0), .TIMEOUT(8)) dut0 (
    .clk(clk), .rstn(rstn), .m_tx(m_tx0), .m_rx(m_rx0), .grant(grant0), .addr(addr0),
    .addr_rdy(addr_rdy0), .slv_ready(slv_ready), .slv_split(slv_split),
    .split_release(split_release), .slv_responded(slv_responded), .timeout_err(terr0)
  );
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    ncmp++;
    if (act !== exp) begin
      nbad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  initial begin
    tbl[0]  = '{4'b1010, 1'b0, 1'b0, 4'b0001, 4'b1110, 2'b00, 1'b0};
    tbl[1]  = '{4'b1010, 1'b0, 1'b0, 4'b0001, 4'b1111, 2'b00, 1'b0};
    tbl[2]  = '{4'b1011, 1'b0, 1'b0, 4'b0001, 4'b1111, 2'b00, 1'b0};
    tbl[3]  = '{4'b1011, 1'b0, 1'b0, 4'b0001, 4'b1111, 2'b11, 1'b1};
    tbl[4]  = '{4'b1011, 1'b1, 1'b0, 4'b0001, 4'b1111, 2'b11, 1'b0};
    tbl[5]  = '{4'b1011, 1'b0, 1'b1, 4'b0000, 4'b1111, 2'b11, 1'b0};
    tbl[6]  = '{4'b1011, 1'b0, 1'b0, 4'b0100, 4'b1011, 2'b11, 1'b0};
    tbl[7]  = '{4'b1011, 1'b0, 1'b0, 4'b0100, 4'b1111, 2'b11, 1'b0};
    tbl[8]  = '{4'b1011, 1'b0, 1'b0, 4'b0100, 4'b1111, 2'b11, 1'b0};
    tbl[9]  = '{4'b1111, 1'b0, 1'b0, 4'b0100, 4'b1111, 2'b01, 1'b1};
    tbl[10] = '{4'b1111, 1'b1, 1'b0, 4'b0100, 4'b1111, 2'b01, 1'b0};
    tbl[11] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 4'b1111, 2'b01, 1'b0};
    tbl[12] = '{4'b1101, 1'b0, 1'b0, 4'b0010, 4'b1101, 2'b01, 1'b0};
    tbl[13] = '{4'b1101, 1'b0, 1'b0, 4'b0010, 4'b1111, 2'b01, 1'b0};
    tbl[14] = '{4'b1111, 1'b0, 1'b0, 4'b0010, 4'b1111, 2'b01, 1'b0};
    tbl[15] = '{4'b1101, 1'b0, 1'b0, 4'b0010, 4'b1111, 2'b10, 1'b1};
    tbl[16] = '{4'b1111, 1'b1, 1'b0, 4'b0010, 4'b1111, 2'b10, 1'b0};
    tbl[17] = '{4'b1111, 1'b0, 1'b1, 4'b0000, 4'b1111, 2'b10, 1'b0};
    tbl[18] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 4'b1111, 2'b10, 1'b0};
    cyc();
    chk("rst_grant", grant, 4'h0);
    chk("rst_m_rx", m_rx, 4'hF);
    chk("rst_addr", addr, 2'b00);
    chk("rst_rdy", addr_rdy, 1'b0);
    chk("rst_terr", terr, 1'b0);
    rstn = 1'b1;
    for (int i = 0; i < 19; i++) begin
      m_tx = tbl[i].tx;
      slv_ready = tbl[i].sr;
      slv_responded = tbl[i].rs;
      cyc();
      chk($sformatf("v%0d_grant", i), grant, tbl[i].eg);
      chk($sformatf("v%0d_m_rx", i), m_rx, tbl[i].erx);
      chk($sformatf("v%0d_addr", i), addr, tbl[i].ea);
      chk($sformatf("v%0d_rdy", i), addr_rdy, tbl[i].ear);
      chk($sformatf("v%0d_terr", i), terr, 1'b0);
    end
    slv_ready = 1'b0;
    slv_responded = 1'b0;
    // split: master 0 parks with addr 01, master 3 runs, release replays master 0
    m_tx = 4'b1110; cyc(); chk("sp_g0", grant, 4'b0001);
    cyc();
    m_tx = 4'b1110; cyc();
    m_tx = 4'b1111; cyc(); chk("sp_addr0", addr, 2'b01); chk("sp_rdy0", addr_rdy, 1'b1);
    slv_split = 1'b1; cyc(); slv_split = 1'b0; chk("sp_park_g", grant, 4'b0000);
    m_tx = 4'b0110; cyc(); chk("sp_g3", grant, 4'b1000);
    cyc();
    m_tx = 4'b1110; cyc();
    m_tx = 4'b0110; cyc(); chk("sp_addr3", addr, 2'b10); chk("sp_rdy3", addr_rdy, 1'b1);
    slv_ready = 1'b1; cyc(); slv_ready = 1'b0;
    slv_responded = 1'b1; cyc(); slv_responded = 1'b0; chk("sp_done3", grant, 4'b0000);
    m_tx = 4'b1110; cyc(); chk("sp_parked_excl", grant, 4'b0000);
    split_release = 1'b1; cyc(); split_release = 1'b0;
    chk("sp_rel_g", grant, 4'b0001); chk("sp_rel_ack", m_rx, 4'b1110);
    m_tx = 4'b1111; cyc(); chk("sp_replay_rdy", addr_rdy, 1'b1); chk("sp_replay_addr", addr, 2'b01);
    slv_ready = 1'b1; cyc(); slv_ready = 1'b0;
    slv_responded = 1'b1; cyc(); slv_responded = 1'b0;
    split_release = 1'b1; cyc(); split_release = 1'b0; chk("sp_norel", grant, 4'b0000);
    // timeout after 8 WAIT_SLV cycles
    m_tx = 4'b1101; cyc(); chk("to_g", grant, 4'b0010);
    cyc();
    m_tx = 4'b1111; cyc(); cyc(); chk("to_rdy", addr_rdy, 1'b1);
    for (int i = 0; i < 7; i++) begin
      cyc();
      chk($sformatf("to_wait%0d_terr", i), terr, 1'b0);
      chk($sformatf("to_wait%0d_g", i), grant, 4'b0010);
    end
    cyc(); chk("to_terr", terr, 1'b1); chk("to_g0", grant, 4'b0000); chk("to_nack1", m_rx, 4'b1101);
    cyc(); chk("to_terr_off", terr, 1'b0); chk("to_nack2", m_rx, 4'b1101);
    cyc(); chk("to_rx_idle", m_rx, 4'b1111);
    // second split while parked aborts; release latched outside IDLE
    m_tx = 4'b1011; cyc(); chk("ds_g2", grant, 4'b0100);
    cyc();
    m_tx = 4'b1111; cyc(); cyc();
    slv_split = 1'b1; cyc(); slv_split = 1'b0; chk("ds_park_g", grant, 4'b0000); chk("ds_park_terr", terr, 1'b0);
    m_tx = 4'b0111; cyc(); chk("ds_g3", grant, 4'b1000);
    split_release = 1'b1; cyc(); split_release = 1'b0;
    m_tx = 4'b1111; cyc(); cyc(); chk("ds_rdy3", addr_rdy, 1'b1);
    slv_split = 1'b1; cyc(); slv_split = 1'b0;
    chk("ds_terr", terr, 1'b1); chk("ds_g0", grant, 4'b0000); chk("ds_nack1", m_rx, 4'b0111);
    cyc(); chk("ds_nack2", m_rx, 4'b0111); chk("ds_wait_g", grant, 4'b0000);
    cyc(); chk("ds_replay_g", grant, 4'b0100); chk("ds_replay_ack", m_rx, 4'b1011);
    cyc(); chk("ds_replay_rdy", addr_rdy, 1'b1); chk("ds_replay_addr", addr, 2'b11);
    slv_ready = 1'b1; cyc(); slv_ready = 1'b0;
    slv_responded = 1'b1; cyc(); slv_responded = 1'b0;
    // asynchronous reset while BUSY
    m_tx = 4'b1110; cyc(); chk("rb_g", grant, 4'b0001);
    cyc();
    m_tx = 4'b1111; cyc();
    m_tx = 4'b1110; cyc(); chk("rb_addr", addr, 2'b10);
    m_tx = 4'b1111;
    slv_ready = 1'b1; cyc(); slv_ready = 1'b0;
    #2 rstn = 1'b0;
    #1;
    chk("rb_grant", grant, 4'h0); chk("rb_m_rx", m_rx, 4'hF); chk("rb_addr0", addr, 2'b00);
    chk("rb_rdy", addr_rdy, 1'b0); chk("rb_terr", terr, 1'b0);
    cyc();
    rstn = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk($sformatf("rb_post%0d_rdy", i), addr_rdy, 1'b0);
      chk($sformatf("rb_post%0d_terr", i), terr, 1'b0);
      chk($sformatf("rb_post%0d_g", i), grant, 4'h0);
    end
    // masters 1 and 3 requesting continuously: RR alternates, fixed always picks 1
    for (int t = 0; t < 4; t++) begin
      m_tx = 4'b0101;
      m_tx0 = 4'b0101;
      cyc();
      chk($sformatf("rr_g%0d", t), grant, (t % 2 == 0) ? 4'b0010 : 4'b1000);
      chk($sformatf("fp_g%0d", t), grant0, 4'b0010);
      cyc(); cyc(); cyc();
      slv_ready = 1'b1; cyc(); slv_ready = 1'b0;
      slv_responded = 1'b1; cyc(); slv_responded = 1'b0;
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nbad);
    $finish;
  end
endmodule

// File: doc/bus_arbiter_n.md
BUS_ARBITER_N -- requirements
Module: bus_arbiter_n

Interface
REQ-001 SHALL have parameter NUM_MASTERS, default 4, number of serial masters (2..8).
REQ-002 SHALL have parameter ADDR_W, default 2, slave-address bits shifted in per transaction (1..4).
REQ-003 SHALL have parameter RR_MODE, default 1, 1 = round-robin, 0 = fixed priority (index 0 highest).
REQ-004 SHALL have parameter TIMEOUT, default 255, maximum WAIT_SLV cycles before abort (1..1023).
REQ-005 SHALL have port clk, input, 1, single clock, all state on rising edge.
REQ-006 SHALL have port rstn, input, 1, reset, asynchronous, active-low.
REQ-007 SHALL have port m_tx, input, NUM_MASTERS, master serial lines, idle high, start bit low.
REQ-008 SHALL have port m_rx, output, NUM_MASTERS, arbiter-to-master serial lines, idle high.
REQ-009 SHALL have port grant, output, NUM_MASTERS, one-hot owner of the bus, or all zero.
REQ-010 SHALL have port addr, output, ADDR_W, captured slave address.
REQ-011 SHALL have port addr_rdy, output, 1, one-cycle pulse when addr is valid.
REQ-012 SHALL have port slv_ready, input, 1, addressed slave accepted the transaction.
REQ-013 SHALL have port slv_split, input, 1, addressed slave requests a split.
REQ-014 SHALL have port split_release, input, 1, split slave can now resume.
REQ-015 SHALL have port slv_responded, input, 1, transaction complete.
REQ-016 SHALL have port timeout_err, output, 1, one-cycle pulse on WAIT_SLV timeout.

Function
REQ-017 SHALL implement states IDLE, GRANT, ADDR, WAIT_SLV, BUSY.
REQ-018 IDLE: a master requests when its m_tx is low and it is not split-parked; with any request, pick the winner and go to GRANT next cycle.
REQ-019 RR_MODE=1: search starts at (last_winner+1) mod NUM_MASTERS; RR_MODE=0: lowest index wins.
REQ-020 A pending split-release master SHALL win over all new requests, regardless of mode.
REQ-021 GRANT: assert grant[w], drive m_rx[w] low for exactly one cycle as acknowledge, then go to ADDR.
REQ-022 ADDR: shift ADDR_W bits from m_tx[w], MSB first, one per cycle; after the last bit, pulse addr_rdy for 1 cycle and go to WAIT_SLV.
REQ-023 A replayed split master SHALL skip ADDR: addr is restored from the stored value, and addr_rdy pulses in the cycle after GRANT.
REQ-024 WAIT_SLV: slv_ready -> BUSY; slv_split -> park master w with its addr, drop grant, go to IDLE.
REQ-025 If slv_ready and slv_split are asserted in the same cycle, slv_ready SHALL take precedence.
REQ-026 WAIT_SLV timeout: after TIMEOUT cycles without slv_ready or slv_split, pulse timeout_err, drive m_rx[w] low for 2 cycles (NACK), drop grant, go to IDLE.
REQ-027 BUSY: hold grant until slv_responded, then drop grant and go to IDLE the next cycle; BUSY has no timeout.
REQ-028 At most one master SHALL be split-parked; a second slv_split while one is parked SHALL be treated as a timeout abort.
REQ-029 split_release with no parked master SHALL be ignored; split_release in any non-IDLE state SHALL be latched and served at the next IDLE.
REQ-030 grant SHALL be all zero in IDLE; all m_rx not owned by the winner SHALL stay high.
REQ-031 Minimum latency from request detected in IDLE to addr_rdy SHALL be 2+ADDR_W cycles.

Reset
REQ-032 On rstn low, immediately: state=IDLE, grant=0, m_rx all 1, addr=0, addr_rdy=0, timeout_err=0, counters=0, split park cleared, last_winner=NUM_MASTERS-1.
REQ-033 Reset mid-transaction SHALL abandon the transaction with no addr_rdy or timeout_err pulse; after release, arbitration starts fresh from IDLE.

Structure
REQ-034 The state enum, the STATE_W constant and the max-master bound SHALL be in package bus_pkg.
REQ-035 The winner selection SHALL be sub-module rr_picker (combinational; request vector, last_winner, mode -> one-hot winner plus index); all sequential logic stays in bus_arbiter_n.

Verification
REQ-036 N=4, RR: m_tx[0] and m_tx[2] low together -> grant=0001 first, then 0100 after slv_responded; addr_rdy fires 4 cycles after the request for ADDR_W=2.
REQ-037 Master 1 sends address bits 1,0 -> addr=2'b10 with a single addr_rdy pulse.
REQ-038 slv_split in WAIT_SLV for master 0 (addr 01), master 3 requests and completes, then split_release -> grant=0001 and addr=01 replayed without ADDR shift.
REQ-039 TIMEOUT=8, no slave response -> timeout_err pulse at cycle 8 of WAIT_SLV, m_rx[w] low for 2 cycles, grant=0.
REQ-040 RR_MODE=0, masters 1 and 3 requesting continuously -> master 1 always wins; RR_MODE=1 -> strict 1,3 alternation.
REQ-041 rstn low during BUSY -> outputs at reset values within the same cycle; no spurious pulses after release.
